// File: rtl/row_slide_merge_pkg.sv
// Shared 2048 board definitions: cell/row widths, FSM encoding and the merge score helper.
// Purely declarative; no latency or flow control.
package row_slide_merge_pkg;

  localparam int TILE_W  = 3;
  localparam int ROW_W   = 3 * TILE_W;
  localparam int SCORE_W = 10;

  localparam logic [TILE_W-1:0] EMPTY   = '0;
  localparam logic [TILE_W-1:0] MAX_EXP = TILE_W'(2**TILE_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PROC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Score for a merge producing exponent e+1 is 2**(e+1), zero-extended to SCORE_W.
  function automatic logic [SCORE_W-1:0] merge_score(input logic [TILE_W-1:0] e);
    logic [SCORE_W-1:0] one;
    one = SCORE_W'(1);
    return one << (int'(e) + 1);
  endfunction

endpackage

// File: rtl/row_slide_merge_if.sv
// Request/result bundle between the move controller and the slide/merge engine.
// start is sampled only while busy is low; results hold from done until the next accepted start.
interface row_slide_merge_if;
  import row_slide_merge_pkg::*;

  logic               start;
  logic [ROW_W-1:0]   in0;
  logic [ROW_W-1:0]   in1;
  logic [ROW_W-1:0]   in2;
  logic               busy;
  logic               done;
  logic [ROW_W-1:0]   out0;
  logic [ROW_W-1:0]   out1;
  logic [ROW_W-1:0]   out2;
  logic               moved;
  logic [SCORE_W-1:0] score_inc;

  modport master (
    output start, in0, in1, in2,
    input  busy, done, out0, out1, out2, moved, score_inc
  );

  modport slave (
    input  start, in0, in1, in2,
    output busy, done, out0, out1, out2, moved, score_inc
  );

endinterface

// File: rtl/row_slide_merge_row_merge3.sv
// Combinational slide-then-merge of one 3-cell row toward cell 0, at most one merge per row.
// Zero latency; no flow control.
module row_merge3
  import row_slide_merge_pkg::*;
(
  input  logic [ROW_W-1:0]   r_in,
  output logic [ROW_W-1:0]   r_out,
  output logic               changed,
  output logic [SCORE_W-1:0] score
);

  logic [TILE_W-1:0] a, b, c;
  logic [TILE_W-1:0] p, q, r;

  assign a = r_in[0*TILE_W +: TILE_W];
  assign b = r_in[1*TILE_W +: TILE_W];
  assign c = r_in[2*TILE_W +: TILE_W];

  always_comb begin
    p = EMPTY;
    q = EMPTY;
    r = EMPTY;
    if (a != EMPTY) begin
      p = a;
      if (b != EMPTY) begin
        q = b;
        r = c;
      end else begin
        q = c;
      end
    end else if (b != EMPTY) begin
      p = b;
      q = c;
    end else begin
      p = c;
    end
  end

  // Left pair has priority so a freshly merged tile cannot merge again.
  always_comb begin
    r_out = {r, q, p};
    score = '0;
    if (p != EMPTY && p == q && p < MAX_EXP) begin
      r_out = {EMPTY, r, p + TILE_W'(1)};
      score = merge_score(p);
    end else if (q != EMPTY && q == r && q < MAX_EXP) begin
      r_out = {EMPTY, q + TILE_W'(1), p};
      score = merge_score(q);
    end
  end

  assign changed = (r_out != r_in);

endmodule

// File: rtl/row_slide_merge.sv
// One 2048 move on a 3x3 board: captures three rows and runs them one per cycle through a shared row_merge3.
// done appears 4 cycles after an accepted start; start is ignored (not queued) while busy.
module row_slide_merge
  import row_slide_merge_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  row_slide_merge_if.slave  bus
);

  state_t             state, state_nxt;
  logic [1:0]         row_idx;
  logic [ROW_W-1:0]   row0, row1, row2;
  logic [ROW_W-1:0]   row_sel;
  logic [ROW_W-1:0]   row_res;
  logic               row_changed;
  logic [SCORE_W-1:0] row_score;
  logic [ROW_W-1:0]   out0, out1, out2;
  logic               moved;
  logic [SCORE_W-1:0] score_inc;

  always_comb begin
    case (row_idx)
      2'd0:    row_sel = row0;
      2'd1:    row_sel = row1;
      default: row_sel = row2;
    endcase
  end

  row_merge3 u_row_merge3 (
    .r_in    (row_sel),
    .r_out   (row_res),
    .changed (row_changed),
    .score   (row_score)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = PROC;
      PROC:    if (row_idx == 2'd2) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_idx   <= 2'd0;
      row0      <= '0;
      row1      <= '0;
      row2      <= '0;
      out0      <= '0;
      out1      <= '0;
      out2      <= '0;
      moved     <= 1'b0;
      score_inc <= '0;
    end else begin
      if (state == IDLE && bus.start) begin
        row0      <= bus.in0;
        row1      <= bus.in1;
        row2      <= bus.in2;
        row_idx   <= 2'd0;
        moved     <= 1'b0;
        score_inc <= '0;
      end else if (state == PROC) begin
        case (row_idx)
          2'd0:    out0 <= row_res;
          2'd1:    out1 <= row_res;
          default: out2 <= row_res;
        endcase
        moved     <= moved | row_changed;
        score_inc <= score_inc + row_score;
        row_idx   <= (row_idx == 2'd2) ? 2'd0 : row_idx + 2'd1;
      end
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == DONE);
  assign bus.out0      = out0;
  assign bus.out1      = out1;
  assign bus.out2      = out2;
  assign bus.moved     = moved;
  assign bus.score_inc = score_inc;

endmodule

// File: tb/tb_row_slide_merge.sv
// Bench for row_slide_merge: a cycle-level reference model checked every cycle plus directed literal checks.
module tb_row_slide_merge;
  import row_slide_merge_pkg::*;

  logic clk = 1'b0;
  logic rst;

  row_slide_merge_if bus();

  row_slide_merge dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] pk(input int c0, input int c1, input int c2);
    return {3'(c2), 3'(c1), 3'(c0)};
  endfunction

  // Reference row rule: gather tiles in order, merge the first equal pair below 7, refill.
  task automatic model_row(input logic [8:0] row, output logic [8:0] res, output int sc);
    int t[$];
    int c;
    t = {};
    for (int k = 0; k < 3; k++) begin
      c = int'(row[3*k +: 3]);
      if (c != 0) t.push_back(c);
    end
    sc = 0;
    for (int i = 0; i + 1 < t.size(); i++) begin
      if (t[i] == t[i+1] && t[i] < 7) begin
        t[i] = t[i] + 1;
        sc = 1 << t[i];
        t.delete(i + 1);
        break;
      end
    end
    res = '0;
    for (int k = 0; k < t.size(); k++) res[3*k +: 3] = 3'(t[k]);
  endtask

  // Model state: cycle of the accepted start, outputs before and after that move.
  int          cyc     = 0;
  int          acc_cyc = -1000;
  logic [8:0]  m_prev[3] = '{default: '0};
  logic [8:0]  m_new[3]  = '{default: '0};
  bit          m_chg[3]  = '{default: 1'b0};
  int          m_sc[3]   = '{default: 0};
  bit          chk_en    = 1'b0;

  always @(posedge clk or posedge rst) begin
    bit         was_busy;
    logic [8:0] cap[3];
    if (rst) begin
      acc_cyc = cyc - 1000;
      for (int k = 0; k < 3; k++) begin
        m_prev[k] = '0;
        m_new[k]  = '0;
        m_chg[k]  = 1'b0;
        m_sc[k]   = 0;
      end
    end else begin
      was_busy = (cyc - acc_cyc) <= 3;
      cyc++;
      if (bus.start && !was_busy) begin
        acc_cyc = cyc;
        cap[0] = bus.in0;
        cap[1] = bus.in1;
        cap[2] = bus.in2;
        for (int k = 0; k < 3; k++) begin
          m_prev[k] = m_new[k];
          model_row(cap[k], m_new[k], m_sc[k]);
          m_chg[k] = (m_new[k] != cap[k]);
        end
      end
    end
  end

  // Row k is rewritten on the (k+1)-th edge after acceptance; done on the 4th cycle.
  always @(negedge clk) begin
    int d;
    bit em;
    int es;
    if (chk_en && !rst) begin
      d  = cyc - acc_cyc;
      em = 1'b0;
      es = 0;
      for (int k = 0; k < 3; k++) begin
        if (d >= k + 1) begin
          em = em | m_chg[k];
          es = es + m_sc[k];
        end
      end
      chk("cyc_busy",  int'(bus.busy), int'(d <= 3));
      chk("cyc_done",  int'(bus.done), int'(d == 3));
      chk("cyc_out0",  int'(bus.out0), int'((d >= 1) ? m_new[0] : m_prev[0]));
      chk("cyc_out1",  int'(bus.out1), int'((d >= 2) ? m_new[1] : m_prev[1]));
      chk("cyc_out2",  int'(bus.out2), int'((d >= 3) ? m_new[2] : m_prev[2]));
      chk("cyc_moved", int'(bus.moved), int'(em));
      chk("cyc_score", int'(bus.score_inc), es);
    end
  end

  task automatic check_outs(input string name, input logic [8:0] e0, input logic [8:0] e1,
                            input logic [8:0] e2, input int em, input int es);
    chk({name, "_out0"},  int'(bus.out0), int'(e0));
    chk({name, "_out1"},  int'(bus.out1), int'(e1));
    chk({name, "_out2"},  int'(bus.out2), int'(e2));
    chk({name, "_moved"}, int'(bus.moved), em);
    chk({name, "_score"}, int'(bus.score_inc), es);
  endtask

  task automatic run_move(input string name,
                          input logic [8:0] r0, input logic [8:0] r1, input logic [8:0] r2,
                          input logic [8:0] e0, input logic [8:0] e1, input logic [8:0] e2,
                          input int em, input int es);
    int n;
    bus.in0   = r0;
    bus.in1   = r1;
    bus.in2   = r2;
    bus.start = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      if (n == 0) begin
        bus.start = 1'b0;
        bus.in0 = ~r0;
        bus.in1 = ~r1;
        bus.in2 = ~r2;
      end
      n++;
    end while (!bus.done && n < 10);
    chk({name, "_latency"}, n, 4);
    check_outs(name, e0, e1, e2, em, es);
    @(negedge clk);
  endtask

  logic [8:0] mres;
  int         msc;
  int         ndone;

  initial begin
    bus.start = 1'b0;
    bus.in0   = '0;
    bus.in1   = '0;
    bus.in2   = '0;
    rst       = 1'b0;
    #1 rst    = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    check_outs("rst", 9'd0, 9'd0, 9'd0, 0, 0);
    rst    = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);

    model_row(pk(1,1,1), mres, msc);
    chk("model_111_row", int'(mres), int'(pk(2,1,0)));
    chk("model_111_sc",  msc, 4);
    model_row(pk(0,7,7), mres, msc);
    chk("model_077_row", int'(mres), int'(pk(7,7,0)));
    chk("model_077_sc",  msc, 0);
    model_row(pk(2,0,2), mres, msc);
    chk("model_202_row", int'(mres), int'(pk(3,0,0)));
    chk("model_202_sc",  msc, 8);

    run_move("t1", pk(1,1,0), pk(1,1,0), pk(1,1,0), pk(2,0,0), pk(2,0,0), pk(2,0,0), 1, 12);
    run_move("t2", pk(0,0,2), pk(0,0,0), pk(0,0,0), pk(2,0,0), pk(0,0,0), pk(0,0,0), 1, 0);
    run_move("t3a", pk(1,1,1), pk(0,0,0), pk(0,0,0), pk(2,1,0), pk(0,0,0), pk(0,0,0), 1, 4);
    run_move("t3b", pk(0,3,3), pk(0,0,0), pk(0,0,0), pk(4,0,0), pk(0,0,0), pk(0,0,0), 1, 16);
    run_move("t4a", pk(7,7,0), pk(1,2,3), pk(0,0,0), pk(7,7,0), pk(1,2,3), pk(0,0,0), 0, 0);
    run_move("t4b", pk(0,7,7), pk(0,0,0), pk(0,0,0), pk(7,7,0), pk(0,0,0), pk(0,0,0), 1, 0);
    run_move("tmax", pk(6,6,0), pk(0,6,6), pk(6,0,6), pk(7,0,0), pk(7,0,0), pk(7,0,0), 1, 384);
    run_move("tmix", pk(2,2,2), pk(0,1,0), pk(3,4,5), pk(3,2,0), pk(1,0,0), pk(3,4,5), 1, 8);

    // start held high through the busy window, inputs changed after capture
    bus.in0   = pk(2,2,0);
    bus.in1   = pk(2,2,0);
    bus.in2   = pk(2,2,0);
    bus.start = 1'b1;
    ndone = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 1) begin
        bus.in0 = pk(1,1,0);
        bus.in1 = pk(1,1,0);
        bus.in2 = pk(1,1,0);
      end
      if (i == 5) bus.start = 1'b0;
      ndone += int'(bus.done);
    end
    chk("t5_done_count", ndone, 1);
    check_outs("t5_hold", pk(3,0,0), pk(3,0,0), pk(3,0,0), 1, 24);
    run_move("t5_next", pk(1,1,0), pk(1,1,0), pk(1,1,0), pk(2,0,0), pk(2,0,0), pk(2,0,0), 1, 12);

    // reset while the second row is being processed
    bus.in0   = pk(3,3,0);
    bus.in1   = pk(0,2,2);
    bus.in2   = pk(1,0,1);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t6_busy", int'(bus.busy), 0);
    chk("t6_done", int'(bus.done), 0);
    check_outs("t6_rst", 9'd0, 9'd0, 9'd0, 0, 0);
    #1 rst = 1'b0;
    ndone = 0;
    repeat (6) begin
      @(negedge clk);
      ndone += int'(bus.done);
    end
    chk("t6_no_done", ndone, 0);
    run_move("t6_fresh", pk(3,3,0), pk(0,2,2), pk(1,0,1), pk(4,0,0), pk(3,0,0), pk(2,0,0), 1, 28);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
